serial_frame_decoder: RTL and testbench
=======================================

Name: serial_frame_decoder

Overview:
- Serial-in/parallel-out receiver for the 9-slot serial frame our PISO encoder produces.
- Frame format: 8 data bits, LSB first, one per clock, followed by a 1-cycle load gap.
- Aligns to the frame on a sync pulse, then free-runs frame to frame and reassembles each byte.
- Presents each byte on a valid/ready output register with overrun detection; sits at the far end of the serial link, feeding downstream byte consumers.

Parameters:
- DATA_WIDTH, 8, bits per frame; shifted in LSB first.
- GAP_CYCLES, 1, idle slots after the last data bit before the next frame's bit 0. Range 0..15.

Ports:
- clock  input  1  rising-edge clock, shared with the encoder.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data, sampled on every rising edge.
- frame_sync  input  1  high in the cycle where serial_in carries bit 0 of a frame.
- data_out  output  DATA_WIDTH  last completed word; bit 0 is the first bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out at an edge where data_valid=1.
- overrun  output  1  sticky: a completed word was dropped because data_out was still full.
- locked  output  1  decoder is tracking frame boundaries (state is not IDLE).

Behaviour:
- Reset (clock edge with reset=1):
  - State goes to IDLE.
  - data_out=0, data_valid=0, overrun=0, locked=0.
  - Shift register and counters are cleared.
  - Reset mid-frame discards the partial word; a pending data_out word is lost.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Ignores serial_in.
  - On an edge with frame_sync=1: shift in serial_in as bit 0, set bit_cnt=1, go to SHIFT.
- SHIFT:
  - Each edge: shreg <= {serial_in, shreg[W-1:1]}, bit_cnt++.
  - On the edge sampling bit W-1: the word is complete. Go to GAP, or to SHIFT with bit_cnt=0 if GAP_CYCLES=0.
- GAP:
  - serial_in is ignored for GAP_CYCLES edges, counted by gap_cnt.
  - Then return to SHIFT with bit_cnt=0; the next edge samples bit 0 without needing frame_sync.
- Resync:
  - frame_sync=1 in SHIFT with bit_cnt!=0, or in GAP: discard the partial word and treat this cycle's serial_in as bit 0 (bit_cnt=1, SHIFT).
  - frame_sync=1 at the expected bit-0 slot is a no-op confirmation.
- Output latency: data_out and data_valid update at the same edge that samples the last bit. Both are visible in the following cycle, 1 cycle after the last bit is on the line.
- Handshake:
  - data_valid stays high, and data_out stays stable, until an edge with data_valid&data_ready.
  - At that edge data_valid clears, unless a new word completes at the same edge.
  - Simultaneous consume and completion: the new word loads, data_valid stays 1, no overrun.
  - Completion while data_valid=1 and data_ready=0: the new word is dropped, data_out is kept, overrun is set to 1 and stays set until reset.
- data_ready is ignored while data_valid=0.
- locked=1 in SHIFT and GAP.

Test Plan:
- Reset with stream activity → all outputs 0, state IDLE, and no words emitted until frame_sync arrives.
- frame_sync with bit 0, then serial bits LSB-first of 0xA5, then 1 gap cycle, with data_ready=1 → data_out=0xA5 and data_valid=1 exactly 1 cycle after bit 7. data_valid drops the next cycle.
- Back-to-back frames 0x3C, 0xFF, 0x01 with a single initial sync, each separated by 1 gap cycle whose line value is the repeated bit 7 → three words in order, one every 9 cycles, locked stays 1.
- data_ready=0 across two frames 0x11 and 0x22 → data_out holds 0x11 and overrun=1 after the second frame. Then data_ready=1 → valid clears and overrun stays 1. Completion and consume in the same cycle → new word loads, overrun unchanged.
- frame_sync asserted mid-frame at bit_cnt=4, followed by 8 bits of 0x5A → partial discarded, only 0x5A emitted.
- Reset asserted while bit_cnt=5 with data_valid=1 → outputs 0 the next cycle and locked=0. The next frame_sync restarts cleanly.

Source files
------------

// File: rtl/serial_frame_decoder.sv
// Serial-in/parallel-out receiver for the PISO frame format: DATA_WIDTH bits LSB first,
// then GAP_CYCLES idle slots. Aligns on frame_sync and presents words on a valid/ready register.
module serial_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  frame_sync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  output logic                  locked
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  locked_q, locked_d;

  logic                  sample_s;
  logic [CNT_W-1:0]      bit_idx_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic                  complete_s;
  logic                  gap_done_s;

  // Next-state, shift register, counters and output-register logic.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    sample_s     = 1'b0;
    bit_idx_s    = {CNT_W{1'b0}};
    complete_s   = 1'b0;
    shifted_s    = {serial_in, shreg_q[DATA_WIDTH-1:1]};
    gap_done_s   = (({1'b0, gap_cnt_q} + 5'd1) == 5'(GAP_CYCLES));

    // A sync pulse always forces the current sample to be bit 0 (resync or confirmation).
    case (state_q)
      IDLE: begin
        if (frame_sync) begin
          sample_s = 1'b1;
        end else begin
          sample_s = 1'b0;
        end
      end
      SHIFT: begin
        sample_s  = 1'b1;
        bit_idx_s = frame_sync ? {CNT_W{1'b0}} : bit_cnt_q;
      end
      GAP: begin
        if (frame_sync) begin
          sample_s = 1'b1;
        end else if (gap_done_s) begin
          state_d   = SHIFT;
          bit_cnt_d = {CNT_W{1'b0}};
          gap_cnt_d = 4'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_s) begin
      shreg_d = shifted_s;
      if (bit_idx_s == CNT_W'(DATA_WIDTH - 1)) begin
        complete_s = 1'b1;
        bit_cnt_d  = {CNT_W{1'b0}};
        gap_cnt_d  = 4'd0;
        state_d    = (GAP_CYCLES == 0) ? SHIFT : GAP;
      end else begin
        bit_cnt_d  = bit_idx_s + CNT_W'(1);
        state_d    = SHIFT;
      end
    end else begin
      shreg_d = shreg_q;
    end

    // A completed word only loads if the output register is empty or being consumed now.
    if (complete_s) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shifted_s;
        data_valid_d = 1'b1;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end

    locked_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= {DATA_WIDTH{1'b0}};
      bit_cnt_q    <= {CNT_W{1'b0}};
      gap_cnt_q    <= 4'd0;
      data_out_q   <= {DATA_WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      locked_q     <= locked_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Scoreboard bench for serial_frame_decoder: a frame-position model predicts accepted words,
// and a negedge monitor pops them whenever the DUT completes a valid/ready handshake.
module tb_serial_frame_decoder;

  localparam int W   = 8;
  localparam int GAP = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         serial_in;
  logic         frame_sync;
  logic         data_ready;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         overrun;
  logic         locked;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] sb[$];
  int           m_pos;
  logic         m_valid;
  logic         m_ovr;
  logic [W-1:0] m_bits;
  bit           mon_en = 1'b0;

  serial_frame_decoder #(.DATA_WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .serial_in  (serial_in),
    .frame_sync (frame_sync),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .locked     (locked)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: m_pos = -1 when unaligned, 0..W-1 = index of next data bit, W..W+GAP-1 = gap slot.
  task automatic model_edge(input logic rst, input logic sync, input logic sin, input logic rdy);
    logic done;
    done = 1'b0;
    if (rst) begin
      m_pos   = -1;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_bits  = '0;
      sb.delete();
    end else begin
      if (sync) begin
        m_bits[0] = sin;
        m_pos     = 1;
      end else if (m_pos >= 0 && m_pos < W) begin
        m_bits[m_pos] = sin;
        m_pos++;
        if (m_pos == W) begin
          done = 1'b1;
          if (GAP == 0) m_pos = 0;
        end
      end else if (m_pos >= W) begin
        m_pos++;
        if (m_pos == W + GAP) m_pos = 0;
      end
      if (done) begin
        if (!m_valid || rdy) begin
          sb.push_back(m_bits);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic rst, input logic sync, input logic sin, input logic rdy);
    reset      = rst;
    frame_sync = sync;
    serial_in  = sin;
    data_ready = rdy;
    @(posedge clock);
    model_edge(rst, sync, sin, rdy);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] b, input logic sync0, input logic rdy,
                           input logic rdy_last);
    for (int i = 0; i < W; i++)
      tick(1'b0, (i == 0) ? sync0 : 1'b0, b[i], (i == W - 1) ? rdy_last : rdy);
  endtask

  task automatic gap_slots(input logic rdy, input logic val);
    for (int i = 0; i < GAP; i++) tick(1'b0, 1'b0, val, rdy);
  endtask

  // Monitor: compare flags every cycle, pop the scoreboard on each handshake.
  always @(negedge clock) begin
    logic [W-1:0] exp_word;
    if (mon_en) begin
      check("mon_valid", 32'(data_valid), 32'(m_valid));
      check("mon_overrun", 32'(overrun), 32'(m_ovr));
      check("mon_locked", 32'(locked), 32'(m_pos >= 0));
      if (data_valid === 1'b1 && data_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", data_out);
        end else begin
          exp_word = sb.pop_front();
          check("mon_data_out", 32'(data_out), 32'(exp_word));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    reset = 1'b1; frame_sync = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
    m_pos = -1; m_valid = 1'b0; m_ovr = 1'b0; m_bits = '0;

    for (int i = 0; i < 4; i++) tick(1'b1, rbit(), rbit(), rbit());
    mon_en = 1'b1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, rbit(), rbit());
    check("idle_no_lock", 32'(locked), 32'd0);
    check("idle_no_word", 32'(data_valid), 32'd0);

    send_bits(8'hA5, 1'b1, 1'b1, 1'b1);
    check("a5_valid", 32'(data_valid), 32'd1);
    check("a5_data", 32'(data_out), 32'hA5);
    gap_slots(1'b1, 1'b1);
    check("a5_valid_drop", 32'(data_valid), 32'd0);

    send_bits(8'h3C, 1'b1, 1'b1, 1'b1);
    check("b2b_3c", 32'(data_out), 32'h3C);
    gap_slots(1'b1, 1'b0);
    send_bits(8'hFF, 1'b0, 1'b1, 1'b1);
    check("b2b_ff", 32'(data_out), 32'hFF);
    gap_slots(1'b1, 1'b1);
    send_bits(8'h01, 1'b0, 1'b1, 1'b1);
    check("b2b_01", 32'(data_out), 32'h01);
    check("b2b_locked", 32'(locked), 32'd1);
    gap_slots(1'b1, 1'b0);

    send_bits(8'h11, 1'b0, 1'b0, 1'b0);
    gap_slots(1'b0, 1'b0);
    send_bits(8'h22, 1'b0, 1'b0, 1'b0);
    check("ovr_hold_data", 32'(data_out), 32'h11);
    check("ovr_set", 32'(overrun), 32'd1);
    gap_slots(1'b0, 1'b0);
    v = 8'h33;
    tick(1'b0, 1'b0, v[0], 1'b1);
    check("ovr_consume_valid", 32'(data_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    for (int i = 1; i < W; i++) tick(1'b0, 1'b0, v[i], 1'b0);
    check("ovr_33", 32'(data_out), 32'h33);
    gap_slots(1'b0, v[W-1]);
    send_bits(8'h44, 1'b0, 1'b0, 1'b1);
    check("same_cycle_data", 32'(data_out), 32'h44);
    check("same_cycle_valid", 32'(data_valid), 32'd1);
    check("same_cycle_ovr", 32'(overrun), 32'd1);
    gap_slots(1'b1, 1'b0);

    tick(1'b0, 1'b1, rbit(), 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, rbit(), 1'b1);
    send_bits(8'h5A, 1'b1, 1'b1, 1'b1);
    check("resync_5a", 32'(data_out), 32'h5A);
    gap_slots(1'b1, 1'b0);

    send_bits(8'h77, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(data_valid), 32'd1);
    gap_slots(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, rbit(), 1'b0);
    tick(1'b1, 1'b0, rbit(), 1'b0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, rbit(), rbit());
    send_bits(8'hC3, 1'b1, 1'b1, 1'b1);
    check("restart_c3", 32'(data_out), 32'hC3);
    gap_slots(1'b1, 1'b1);

    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, rbit(), rbit());

    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, rbit(), 1'b1);
    check("drain_queue", 32'(sb.size()), m_valid ? 32'd1 : 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
